// File: rtl/demux_stream_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_stream_dispatch_if
//  Description : Upstream handshake and four-channel downstream bus bundle for
//                the stream dispatcher.
//  Revision    : 1.0
// ============================================================================
interface demux_stream_dispatch_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     d_in;
    logic [1:0]           sel;
    logic                 mode;
    logic [3:0]           y_valid;
    logic [3:0]           y_ready;
    logic [4*WIDTH-1:0]   y_out;
    logic [1:0]           rr_ptr;
    logic [CNT_W-1:0]     acc_cnt;

    modport master (
        output in_valid, d_in, sel, mode, y_ready,
        input  in_ready, y_valid, y_out, rr_ptr, acc_cnt
    );

    modport slave (
        input  in_valid, d_in, sel, mode, y_ready,
        output in_ready, y_valid, y_out, rr_ptr, acc_cnt
    );
endinterface
`default_nettype wire

// File: rtl/demux_stream_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : demux_stream_dispatch
//  Description : One-to-four stream demux with a one-entry holding register per
//                channel, directed or round-robin targeting, saturating counter.
//  Revision    : 1.0
// ============================================================================
module demux_stream_dispatch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    demux_stream_dispatch_if.slave bus
);
    localparam int c_NCH = 4;

    logic [WIDTH-1:0] r_data [c_NCH];
    logic [c_NCH-1:0] r_valid;
    logic [1:0]       r_rr_ptr;
    logic [CNT_W-1:0] r_acc_cnt;

    logic [1:0]       w_tgt;
    logic             w_in_ready;
    logic             w_accept;
    logic [c_NCH-1:0] w_load;
    logic [c_NCH-1:0] w_drain;

    assign w_tgt      = bus.mode ? r_rr_ptr : bus.sel;
    assign w_in_ready = ~r_valid[w_tgt] | bus.y_ready[w_tgt];
    assign w_accept   = bus.in_valid & w_in_ready;

    generate
        for (genvar k = 0; k < c_NCH; k++) begin : g_ch
            assign w_load[k]  = w_accept && (w_tgt == 2'(k));
            assign w_drain[k] = r_valid[k] & bus.y_ready[k];
            assign bus.y_out[k*WIDTH +: WIDTH] = r_data[k];
        end
    endgenerate

    // A load wins over a same-edge drain so the channel refills with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < c_NCH; k++) begin
                r_data[k] <= '0;
            end
            r_valid   <= '0;
            r_rr_ptr  <= 2'd0;
            r_acc_cnt <= '0;
        end else begin
            for (int k = 0; k < c_NCH; k++) begin
                if (w_load[k]) begin
                    r_data[k]  <= bus.d_in;
                    r_valid[k] <= 1'b1;
                end else if (w_drain[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            if (w_accept && bus.mode) begin
                r_rr_ptr <= r_rr_ptr + 2'd1;
            end
            if (w_accept && (r_acc_cnt != {CNT_W{1'b1}})) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.y_valid  = r_valid;
    assign bus.rr_ptr   = r_rr_ptr;
    assign bus.acc_cnt  = r_acc_cnt;
endmodule
`default_nettype wire

// File: tb/tb_demux_stream_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_stream_dispatch
//  Description : Directed and random checks of the dispatcher against a
//                channel-occupancy reference model.
//  Revision    : 1.0
// ============================================================================
module tb_demux_stream_dispatch;
    logic clk;
    logic rst;

    demux_stream_dispatch_if #(.WIDTH(8), .CNT_W(16)) bus  ();
    demux_stream_dispatch_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

    demux_stream_dispatch #(.WIDTH(8), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    demux_stream_dispatch #(.WIDTH(8), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // The narrow-counter instance sees the identical input stream.
    assign bus4.in_valid = bus.in_valid;
    assign bus4.d_in     = bus.d_in;
    assign bus4.sel      = bus.sel;
    assign bus4.mode     = bus.mode;
    assign bus4.y_ready  = bus.y_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    logic [3:0]  mv;
    logic [7:0]  md [4];
    logic [1:0]  mp;
    int unsigned tot;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv  = 4'b0000;
        mp  = 2'd0;
        tot = 0;
        for (int k = 0; k < 4; k++) md[k] = 8'h00;
    endtask

    task automatic check_state();
        logic [31:0] mask;
        logic [31:0] expd;
        mask = '0;
        expd = '0;
        for (int k = 0; k < 4; k++) begin
            if (mv[k]) begin
                mask[k*8 +: 8] = 8'hFF;
                expd[k*8 +: 8] = md[k];
            end
        end
        chk("y_valid", 64'(bus.y_valid), 64'(mv));
        chk("y_out", 64'(bus.y_out & mask), 64'(expd));
        chk("rr_ptr", 64'(bus.rr_ptr), 64'(mp));
        chk("acc_cnt", 64'(bus.acc_cnt), 64'((tot > 65535) ? 65535 : tot));
        chk("acc_cnt4", 64'(bus4.acc_cnt), 64'((tot > 15) ? 15 : tot));
    endtask

    // One clock of stimulus: check in_ready before the edge, state after it.
    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] s,
                        input logic m, input logic [3:0] yr, input logic r);
        logic [1:0] t;
        logic       rdy;
        logic       acc;
        bus.in_valid = v;
        bus.d_in     = d;
        bus.sel      = s;
        bus.mode     = m;
        bus.y_ready  = yr;
        rst          = r;
        #1;
        t   = m ? mp : s;
        rdy = !mv[t] || yr[t];
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        acc = v && rdy;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc && (int'(t) == k)) begin
                    mv[k] = 1'b1;
                    md[k] = d;
                end else if (mv[k] && yr[k]) begin
                    mv[k] = 1'b0;
                end
            end
            if (acc) begin
                tot++;
                if (m) mp = mp + 2'd1;
            end
        end
        #1;
        check_state();
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.d_in     = 8'h00;
        bus.sel      = 2'd0;
        bus.mode     = 1'b0;
        bus.y_ready  = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;
        step(1'b1, 8'hEE, 2'd1, 1'b1, 4'b0000, 1'b1);
        chk("rst_y_out", 64'(bus.y_out), 64'd0);

        // Directed mode, stall on a full channel, then refill while draining.
        step(1'b1, 8'hA5, 2'd2, 1'b0, 4'b0000, 1'b0);
        chk("dir_ch2", 64'(bus.y_out[23:16]), 64'hA5);
        step(1'b1, 8'h5A, 2'd2, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 8'h5A, 2'd2, 1'b0, 4'b0100, 1'b0);
        chk("dir_refill", 64'(bus.y_out[23:16]), 64'h5A);
        step(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111, 1'b0);

        // Round-robin, back-to-back with everything ready.
        step(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 2'd0, 1'b1, 4'b1111, 1'b0);
        chk("rr_after6", 64'(bus.rr_ptr), 64'd2);

        // Backpressure: four fill, fifth stalls until channel 0 frees.
        step(1'b0, 8'h00, 2'd0, 1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 2'd0, 1'b1, 4'b0000, 1'b0);
        step(1'b1, 8'h24, 2'd0, 1'b1, 4'b0001, 1'b0);
        chk("bp_ch0", 64'(bus.y_out[7:0]), 64'h24);

        // Build y_valid=1011 with rr_ptr=3, then reset mid-operation.
        step(1'b0, 8'h00, 2'd0, 1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 2'd0, 1'b1, 4'b0000, 1'b0);
        step(1'b1, 8'h33, 2'd3, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 8'h00, 2'd0, 1'b0, 4'b0100, 1'b0);
        chk("pre_rst_valid", 64'(bus.y_valid), 64'hB);
        step(1'b1, 8'h44, 2'd0, 1'b0, 4'b1111, 1'b1);
        chk("mid_rst_y_out", 64'(bus.y_out), 64'd0);

        // A reset pulse between edges must leave state untouched.
        step(1'b1, 8'h55, 2'd0, 1'b1, 4'b0000, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step(1'b0, 8'h00, 2'd0, 1'b1, 4'b0000, 1'b0);

        // Mode switch keeps the round-robin pointer.
        step(1'b1, 8'h61, 2'd3, 1'b0, 4'b1111, 1'b0);
        step(1'b1, 8'h62, 2'd0, 1'b1, 4'b1111, 1'b0);

        // Counter saturation on the narrow instance.
        step(1'b0, 8'h00, 2'd0, 1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 2'(i), 1'b0, 4'b1111, 1'b0);
        chk("sat4", 64'(bus4.acc_cnt), 64'hF);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), 1'($urandom),
                 4'($urandom), $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/demux_stream_dispatch.md
DEMUX_STREAM_DISPATCH -- requirements
Module: demux_stream_dispatch

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of d_in and of each output channel.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the accepted-beat counter.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  SHALL indicate that upstream data on d_in is valid.
REQ-006 in_ready  output  1  SHALL indicate that the dispatcher accepts the beat this cycle.
REQ-007 d_in  input  WIDTH  SHALL carry the upstream data beat.
REQ-008 sel  input  2  SHALL be the target channel index in directed mode.
REQ-009 mode  input  1  SHALL select the target source: 0 = directed by sel, 1 = round-robin.
REQ-010 y_valid  output  4  SHALL be a per-channel valid, where bit k qualifies channel k.
REQ-011 y_ready  input  4  SHALL be a per-channel downstream ready.
REQ-012 y_out  output  4*WIDTH  SHALL carry the channel data, with channel k at bits [k*WIDTH +: WIDTH].
REQ-013 rr_ptr  output  2  SHALL expose the current round-robin pointer.
REQ-014 acc_cnt  output  CNT_W  SHALL hold the total number of accepted beats.

Function
REQ-015 Each channel SHALL have a one-entry holding register (data and valid bit); y_valid[k] and y_out channel k SHALL be driven directly from that register.
REQ-016 Target index tgt SHALL be rr_ptr when mode=1 and sel when mode=0; tgt SHALL be evaluated combinationally in the same cycle.
REQ-017 in_ready SHALL equal (!y_valid[tgt]) | y_ready[tgt], combinational in mode, sel, rr_ptr and y_ready[tgt].
REQ-018 An accept SHALL occur when in_valid & in_ready at a rising edge; on an accept the register of channel tgt SHALL load d_in and set its valid bit.
REQ-019 Latency SHALL be 1 cycle: data accepted at edge N SHALL appear on y_out with y_valid set immediately after edge N.
REQ-020 A drain on channel k SHALL occur when y_valid[k] & y_ready[k]; a drain without a same-edge accept to k SHALL clear y_valid[k].
REQ-021 On a simultaneous drain and accept to the same channel k, y_valid[k] SHALL stay 1 and channel k SHALL carry the new d_in with no bubble.
REQ-022 Drains on different channels SHALL be independent and SHALL be allowed on the same edge.
REQ-023 While y_valid[k]=1 and y_ready[k]=0, channel k data SHALL remain stable.
REQ-024 When the target channel is full and not draining, in_ready SHALL be 0, no state SHALL change from the input side, and the beat SHALL stay pending upstream.
REQ-025 In mode=1, rr_ptr SHALL advance by 1 on each accept and wrap from 3 to 0; with no accept it SHALL hold.
REQ-026 In mode=0, rr_ptr SHALL hold its value; a change of mode SHALL NOT alter rr_ptr.
REQ-027 sel and mode SHALL affect state only on an accept edge; changing them while in_valid=0 SHALL have no effect.
REQ-028 acc_cnt SHALL increment by 1 on every accept and SHALL saturate at all-ones.
REQ-029 No beat SHALL ever be dropped or duplicated: every accept SHALL produce exactly one drain on exactly one channel.

Reset
REQ-030 While rst=1 at an edge, all y_valid bits, every y_out channel, rr_ptr and acc_cnt SHALL become 0.
REQ-031 Reset SHALL take priority over simultaneous accept and drain.
REQ-032 Buffered beats SHALL be discarded on a reset mid-operation.
REQ-033 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-034 Reset SHALL NOT act asynchronously; an rst pulse between edges SHALL have no effect.

Verification
REQ-035 Directed mode: after reset, send d_in=8'hA5 with sel=2 and mode=0 while y_ready=4'b0000 -> next cycle y_valid=4'b0100, channel 2 = A5 and acc_cnt=1; a second beat to sel=2 sees in_ready=0; then set y_ready[2]=1 -> the second beat is accepted in the same cycle and y_valid stays 4'b0100 with the new data.
REQ-036 Round-robin: with mode=1 and y_ready=4'b1111, send 6 back-to-back beats 8'h10..8'h15 -> they land on channels 0,1,2,3,0,1; rr_ptr reads 2 afterwards; acc_cnt=6; no gaps on in_ready.
REQ-037 Backpressure: with mode=1, y_ready=0 and 5 beats offered -> 4 beats are accepted, y_valid=4'b1111, in_ready=0 on the fifth; raising y_ready[0] only -> the fifth beat is accepted into channel 0.
REQ-038 Reset mid-operation: with y_valid=4'b1011 and rr_ptr=3, assert rst for one edge -> y_valid=0, y_out=0, rr_ptr=0, acc_cnt=0, in_ready=1.
REQ-039 Counter saturation: with CNT_W=4, make 17 accepts -> acc_cnt=4'hF.
REQ-040 Mode switch: with rr_ptr=1, set mode=0 and sel=3 and accept one beat -> the beat goes to channel 3 and rr_ptr stays 1; then set mode=1 and accept one beat -> it goes to channel 1 and rr_ptr=2.
